// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: seeds a local LFSR from the received
// stream, verifies it, then predicts each bit and counts mismatches while locked.
module prbs_checker #(
   parameter int unsigned          NUM_BITS    = 10,
   parameter logic [NUM_BITS-1:0]  TAPS        = 10'h240,
   parameter int unsigned          LOCK_COUNT  = 32,
   parameter int unsigned          UNLOCK_ERRS = 8,
   parameter int unsigned          ERR_WIDTH   = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_bit_valid,
   input  logic                 i_bit_in,
   input  logic                 i_clear,
   output logic                 o_locked,
   output logic                 o_err_pulse,
   output logic [ERR_WIDTH-1:0] o_err_count
);

   localparam int FILL_W  = $clog2(NUM_BITS) + 1;
   localparam int MATCH_W = $clog2(LOCK_COUNT) + 1;
   localparam int RUN_W   = $clog2(UNLOCK_ERRS) + 1;

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t                r_state;
   logic [NUM_BITS-1:0]   r_sr;
   logic [FILL_W-1:0]     r_fill;
   logic [MATCH_W-1:0]    r_match;
   logic [RUN_W-1:0]      r_run;
   logic                  r_locked;
   logic                  r_err_pulse;
   logic [ERR_WIDTH-1:0]  r_err_count;

   logic                  w_pred;
   logic                  w_match;
   logic                  w_shift_bit;
   logic [NUM_BITS-1:0]   w_sr_next;

   // Prediction and next shift-register value; once locked the predicted bit is
   // shifted in so that a channel error is counted exactly once.
   always_comb begin
      w_pred  = ^(r_sr & TAPS);
      w_match = (i_bit_in == w_pred);
      if (r_state == ST_LOCKED) begin
         w_shift_bit = w_pred;
      end else begin
         w_shift_bit = i_bit_in;
      end
      w_sr_next = {r_sr[NUM_BITS-2:0], w_shift_bit};
   end

   // Seed / verify / locked state machine with registered status outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_SEED;
         r_sr        <= {NUM_BITS{1'b0}};
         r_fill      <= {FILL_W{1'b0}};
         r_match     <= {MATCH_W{1'b0}};
         r_run       <= {RUN_W{1'b0}};
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_count <= {ERR_WIDTH{1'b0}};
      end else begin
         r_err_pulse <= 1'b0;
         if (i_clear) begin
            r_err_count <= {ERR_WIDTH{1'b0}};
         end
         if (i_bit_valid) begin
            r_sr <= w_sr_next;
            case (r_state)
               ST_SEED: begin
                  if (r_fill == FILL_W'(NUM_BITS - 1)) begin
                     r_fill <= {FILL_W{1'b0}};
                     // An all-zero fill can never predict a live stream; refill.
                     if (w_sr_next != {NUM_BITS{1'b0}}) begin
                        r_state <= ST_VERIFY;
                        r_match <= {MATCH_W{1'b0}};
                     end
                  end else begin
                     r_fill <= r_fill + FILL_W'(1);
                  end
               end
               ST_VERIFY: begin
                  if (w_match) begin
                     if (r_match == MATCH_W'(LOCK_COUNT - 1)) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                        r_run    <= {RUN_W{1'b0}};
                     end else begin
                        r_match <= r_match + MATCH_W'(1);
                     end
                  end else begin
                     r_state <= ST_SEED;
                     r_fill  <= {FILL_W{1'b0}};
                  end
               end
               ST_LOCKED: begin
                  if (!w_match) begin
                     r_err_pulse <= 1'b1;
                     if (!i_clear && (r_err_count != {ERR_WIDTH{1'b1}})) begin
                        r_err_count <= r_err_count + ERR_WIDTH'(1);
                     end
                     if (r_run == RUN_W'(UNLOCK_ERRS - 1)) begin
                        r_state  <= ST_SEED;
                        r_locked <= 1'b0;
                        r_fill   <= {FILL_W{1'b0}};
                        r_run    <= {RUN_W{1'b0}};
                     end else begin
                        r_run <= r_run + RUN_W'(1);
                     end
                  end else begin
                     r_run <= {RUN_W{1'b0}};
                  end
               end
               default: begin
                  r_state  <= ST_SEED;
                  r_locked <= 1'b0;
                  r_fill   <= {FILL_W{1'b0}};
               end
            endcase
         end
      end
   end

   assign o_locked    = r_locked;
   assign o_err_pulse = r_err_pulse;
   assign o_err_count = r_err_count;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a default instance plus a narrow-counter,
// high-unlock instance for saturation and clear behaviour.
module tb_prbs_checker;

   logic clk       = 1'b0;
   logic rst_n     = 1'b1;
   logic bit_valid = 1'b0;
   logic bit_in    = 1'b0;
   logic clear     = 1'b0;

   logic        locked_a, pulse_a;
   logic [15:0] cnt_a;
   logic        locked_b, pulse_b;
   logic [3:0]  cnt_b;

   int errors = 0;
   int checks = 0;

   logic [9:0] gen;

   typedef struct packed {
      logic        lock;
      logic        pulse;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb_q[$];

   prbs_checker dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_bit_valid(bit_valid), .i_bit_in(bit_in),
      .i_clear(clear), .o_locked(locked_a), .o_err_pulse(pulse_a), .o_err_count(cnt_a)
   );

   prbs_checker #(.ERR_WIDTH(4), .UNLOCK_ERRS(100)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_bit_valid(bit_valid), .i_bit_in(bit_in),
      .i_clear(clear), .o_locked(locked_b), .o_err_pulse(pulse_b), .o_err_count(cnt_b)
   );

   always #5 clk = ~clk;

   // Reference generator: Fibonacci LFSR, output is the newly shifted-in bit.
   task automatic gen_bit(output logic b);
      logic [9:0] taps;
      taps = 10'h240;
      b    = ^(gen & taps);
      gen  = {gen[8:0], b};
   endtask

   task automatic send(input logic v, input logic b);
      bit_valid = v;
      bit_in    = b;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst_n     = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      clear     = 1'b0;
      gen       = 10'd1;
      sb_q.delete();
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2;
      rst_n = 1'b0;
      #1;
      if (locked_a !== 1'b0) begin errors++; $display("FAIL reset_locked_a: got %b want 0", locked_a); end
      checks++;
      if (pulse_a !== 1'b0) begin errors++; $display("FAIL reset_pulse_a: got %b want 0", pulse_a); end
      checks++;
      if (cnt_a !== 16'd0) begin errors++; $display("FAIL reset_cnt_a: got %0d want 0", cnt_a); end
      checks++;
      if (locked_b !== 1'b0) begin errors++; $display("FAIL reset_locked_b: got %b want 0", locked_b); end
      checks++;
      if (pulse_b !== 1'b0) begin errors++; $display("FAIL reset_pulse_b: got %b want 0", pulse_b); end
      checks++;
      if (cnt_b !== 4'd0) begin errors++; $display("FAIL reset_cnt_b: got %0d want 0", cnt_b); end
      checks++;
   endtask

   task automatic test_clean_lock;
      apply_reset();
      for (int k = 1; k <= 2000; k++) begin
         logic b;
         exp_t e;
         gen_bit(b);
         e.lock = (k >= 42); e.pulse = 1'b0; e.cnt = 16'd0;
         sb_q.push_back(e);
         send(1'b1, b);
         e = sb_q.pop_front();
         if (locked_a !== e.lock || pulse_a !== e.pulse || cnt_a !== e.cnt) begin
            errors++;
            $display("FAIL clean_lock bit %0d: got lock=%b pulse=%b cnt=%0d want lock=%b pulse=%b cnt=%0d",
                     k, locked_a, pulse_a, cnt_a, e.lock, e.pulse, e.cnt);
         end
         checks++;
      end
   endtask

   task automatic test_single_error;
      apply_reset();
      for (int k = 1; k <= 143; k++) begin
         logic b;
         logic inv;
         exp_t e;
         gen_bit(b);
         inv     = (k == 43);
         e.lock  = (k >= 42);
         e.pulse = inv;
         e.cnt   = (k >= 43) ? 16'd1 : 16'd0;
         sb_q.push_back(e);
         send(1'b1, b ^ inv);
         e = sb_q.pop_front();
         if (locked_a !== e.lock || pulse_a !== e.pulse || cnt_a !== e.cnt) begin
            errors++;
            $display("FAIL single_error bit %0d: got lock=%b pulse=%b cnt=%0d want lock=%b pulse=%b cnt=%0d",
                     k, locked_a, pulse_a, cnt_a, e.lock, e.pulse, e.cnt);
         end
         checks++;
      end
   endtask

   task automatic test_loss_of_sync;
      apply_reset();
      for (int k = 1; k <= 92; k++) begin
         logic b;
         logic inv;
         exp_t e;
         gen_bit(b);
         inv     = (k >= 43) && (k <= 50);
         e.lock  = ((k >= 42) && (k < 50)) || (k >= 92);
         e.pulse = inv;
         e.cnt   = (k < 43) ? 16'd0 : ((k > 50) ? 16'd8 : 16'(k - 42));
         sb_q.push_back(e);
         send(1'b1, b ^ inv);
         e = sb_q.pop_front();
         if (locked_a !== e.lock || pulse_a !== e.pulse || cnt_a !== e.cnt) begin
            errors++;
            $display("FAIL loss_of_sync bit %0d: got lock=%b pulse=%b cnt=%0d want lock=%b pulse=%b cnt=%0d",
                     k, locked_a, pulse_a, cnt_a, e.lock, e.pulse, e.cnt);
         end
         checks++;
      end
   endtask

   task automatic test_all_zero;
      apply_reset();
      for (int k = 1; k <= 500; k++) begin
         exp_t e;
         e.lock = 1'b0; e.pulse = 1'b0; e.cnt = 16'd0;
         sb_q.push_back(e);
         send(1'b1, 1'b0);
         e = sb_q.pop_front();
         if (locked_a !== e.lock || pulse_a !== e.pulse || cnt_a !== e.cnt) begin
            errors++;
            $display("FAIL all_zero bit %0d: got lock=%b pulse=%b cnt=%0d want lock=%b pulse=%b cnt=%0d",
                     k, locked_a, pulse_a, cnt_a, e.lock, e.pulse, e.cnt);
         end
         checks++;
      end
   endtask

   task automatic test_gapped_valid;
      int vc;
      apply_reset();
      vc = 0;
      for (int k = 1; k <= 200; k++) begin
         logic b;
         logic v;
         exp_t e;
         v = (k % 2) == 1;
         if (v) begin
            gen_bit(b);
            vc++;
         end else begin
            b = 1'($urandom_range(0, 1));
         end
         e.lock = (vc >= 42); e.pulse = 1'b0; e.cnt = 16'd0;
         sb_q.push_back(e);
         send(v, b);
         e = sb_q.pop_front();
         if (locked_a !== e.lock || pulse_a !== e.pulse || cnt_a !== e.cnt) begin
            errors++;
            $display("FAIL gapped_valid cycle %0d: got lock=%b pulse=%b cnt=%0d want lock=%b pulse=%b cnt=%0d",
                     k, locked_a, pulse_a, cnt_a, e.lock, e.pulse, e.cnt);
         end
         checks++;
      end
   endtask

   task automatic test_saturation_clear;
      int errs;
      apply_reset();
      errs = 0;
      for (int k = 1; k <= 102; k++) begin
         logic b;
         logic inv;
         exp_t e;
         gen_bit(b);
         inv = (k > 42) && ((k - 42) % 3 == 0);
         if (inv) errs++;
         e.lock  = (k >= 42);
         e.pulse = inv;
         e.cnt   = (errs > 15) ? 16'd15 : 16'(errs);
         sb_q.push_back(e);
         send(1'b1, b ^ inv);
         e = sb_q.pop_front();
         if (locked_b !== e.lock || pulse_b !== e.pulse || cnt_b !== e.cnt[3:0]) begin
            errors++;
            $display("FAIL saturation bit %0d: got lock=%b pulse=%b cnt=%0d want lock=%b pulse=%b cnt=%0d",
                     k, locked_b, pulse_b, cnt_b, e.lock, e.pulse, e.cnt);
         end
         checks++;
      end
      // clear alone, clear racing an error, then a fresh error after clear
      for (int s = 0; s < 3; s++) begin
         logic b;
         exp_t e;
         clear   = (s < 2);
         e.lock  = 1'b1;
         e.pulse = (s > 0);
         e.cnt   = (s == 2) ? 16'd1 : 16'd0;
         sb_q.push_back(e);
         if (s == 0) begin
            send(1'b0, 1'b0);
         end else begin
            gen_bit(b);
            send(1'b1, ~b);
         end
         clear = 1'b0;
         e = sb_q.pop_front();
         if (locked_b !== e.lock || pulse_b !== e.pulse || cnt_b !== e.cnt[3:0]) begin
            errors++;
            $display("FAIL clear step %0d: got lock=%b pulse=%b cnt=%0d want lock=%b pulse=%b cnt=%0d",
                     s, locked_b, pulse_b, cnt_b, e.lock, e.pulse, e.cnt);
         end
         checks++;
      end
   endtask

   task automatic test_async_reset;
      apply_reset();
      for (int k = 1; k <= 65; k++) begin
         logic b;
         logic inv;
         gen_bit(b);
         inv = (k >= 43) && (k <= 50);
         send(1'b1, b ^ inv);
      end
      // dut_a now sits in VERIFY with 8 counted errors; dut_b stayed locked
      if (locked_a !== 1'b0 || cnt_a !== 16'd8) begin
         errors++;
         $display("FAIL pre_reset_a: got lock=%b cnt=%0d want lock=0 cnt=8", locked_a, cnt_a);
      end
      checks++;
      if (locked_b !== 1'b1 || cnt_b !== 4'd8) begin
         errors++;
         $display("FAIL pre_reset_b: got lock=%b cnt=%0d want lock=1 cnt=8", locked_b, cnt_b);
      end
      checks++;
      #2;
      rst_n = 1'b0;
      #1;
      if (locked_a !== 1'b0 || pulse_a !== 1'b0 || cnt_a !== 16'd0) begin
         errors++;
         $display("FAIL async_reset_a: got lock=%b pulse=%b cnt=%0d want all 0", locked_a, pulse_a, cnt_a);
      end
      checks++;
      if (locked_b !== 1'b0 || pulse_b !== 1'b0 || cnt_b !== 4'd0) begin
         errors++;
         $display("FAIL async_reset_b: got lock=%b pulse=%b cnt=%0d want all 0", locked_b, pulse_b, cnt_b);
      end
      checks++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_single_error();
      test_loss_of_sync();
      test_all_zero();
      test_gapped_valid();
      test_saturation_clear();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
